mem_port_arbiter: RTL

Shares the core's single memory bus port between instruction fetch (IF) and the load/store unit (LSU). It sits between the fetch stage, the LSU and the memory/interconnect port. Each side sees a private req/gnt/rvalid channel. The block allows one outstanding transaction, locks its choice while a request is waiting for grant, and routes each response back to the requester that owns it. Stalls seen by the pipeline controller come only from the requester-side `gnt`/`rvalid` timing.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_port_arbiter_if.sv | 59 +++++
 rtl/mem_port_arbiter_starve_ctr.sv | 35 +++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// riscv_pkg: shared types and constants for the memory port arbiter.
// Rev 1.0
`default_nettype none

package riscv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_WAIT_IF  = 2'd1,
    ARB_WAIT_LSU = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_LSU = 1'b1
  } arb_owner_e;

  localparam int ARB_STARVE_CNT_W = 4;

  function automatic logic [ARB_STARVE_CNT_W-1:0] starve_sat_inc(
    input logic [ARB_STARVE_CNT_W-1:0] value
  );
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, LSU and memory channels of the shared bus port.
// Rev 1.0
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic                lsu_req_i;
  logic                lsu_we_i;
  logic [DATA_W/8-1:0] lsu_be_i;
  logic [ADDR_W-1:0]   lsu_addr_i;
  logic [DATA_W-1:0]   lsu_wdata_i;
  logic                lsu_gnt_o;
  logic                lsu_rvalid_o;
  logic [DATA_W-1:0]   lsu_rdata_o;

  logic                mem_req_o;
  logic                mem_we_o;
  logic [DATA_W/8-1:0] mem_be_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic                mem_gnt_i;
  logic                mem_rvalid_i;
  logic [DATA_W-1:0]   mem_rdata_i;

  logic busy_o;

  // Arbiter view
  modport master (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output busy_o
  );

  // Core and memory view
  modport slave (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  busy_o
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_starve_ctr.sv
// arb_starve_ctr: saturating LSU-grant counter; fires once IF has waited STARVE_LIMIT grants.
// Rev 1.0 -- compiled only when YARC_ARB_FAIRNESS_EN is defined.
`default_nettype none

`ifdef YARC_ARB_FAIRNESS_EN
module arb_starve_ctr
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic clr,
  output logic fire
);

  logic [ARB_STARVE_CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (clr) begin
      starve_cnt <= '0;
    end else if (inc) begin
      starve_cnt <= starve_sat_inc(starve_cnt);
    end
  end

  assign fire = (starve_cnt >= ARB_STARVE_CNT_W'(STARVE_LIMIT));

endmodule
`endif

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and LSU, one outstanding access,
// locked selection while waiting for grant. Fairness guard under YARC_ARB_FAIRNESS_EN. Rev 1.0
`default_nettype none

module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.master  bus
);

  arb_state_e state, state_next;
  logic       lock_valid, lock_valid_next;
  arb_owner_e lock_owner, lock_owner_next;

  logic       sel_valid;
  arb_owner_e sel_owner;
  logic       issue;
  logic       starve_fire;

  logic                cmd_we;
  logic [DATA_W/8-1:0] cmd_be;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;

`ifdef YARC_ARB_FAIRNESS_EN
  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (bus.lsu_gnt_o & bus.if_req_i),
    .clr   (bus.if_gnt_o),
    .fire  (starve_fire)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign starve_fire         = 1'b0;
`endif

  // A locked owner keeps its request high, so it is always still requesting.
  always_comb begin
    sel_valid = 1'b0;
    sel_owner = OWNER_IF;
    if (lock_valid) begin
      sel_valid = 1'b1;
      sel_owner = lock_owner;
    end else if (starve_fire && bus.if_req_i) begin
      sel_valid = 1'b1;
      sel_owner = OWNER_IF;
    end else if (bus.lsu_req_i) begin
      sel_valid = 1'b1;
      sel_owner = OWNER_LSU;
    end else if (bus.if_req_i) begin
      sel_valid = 1'b1;
      sel_owner = OWNER_IF;
    end
  end

  assign issue = (state == ARB_IDLE) && sel_valid &&
                 ((sel_owner == OWNER_LSU) ? bus.lsu_req_i : bus.if_req_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ARB_IDLE;
      lock_valid <= 1'b0;
      lock_owner <= OWNER_IF;
    end else begin
      state      <= state_next;
      lock_valid <= lock_valid_next;
      lock_owner <= lock_owner_next;
    end
  end

  always_comb begin
    state_next       = state;
    lock_valid_next  = lock_valid;
    lock_owner_next  = lock_owner;
    bus.mem_req_o    = 1'b0;
    cmd_we           = 1'b0;
    cmd_be           = '0;
    cmd_addr         = '0;
    cmd_wdata        = '0;
    bus.if_gnt_o     = 1'b0;
    bus.lsu_gnt_o    = 1'b0;
    bus.if_rvalid_o  = 1'b0;
    bus.lsu_rvalid_o = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (issue) begin
          bus.mem_req_o = 1'b1;
          if (sel_owner == OWNER_LSU) begin
            cmd_we    = bus.lsu_we_i;
            cmd_be    = bus.lsu_be_i;
            cmd_addr  = bus.lsu_addr_i;
            cmd_wdata = bus.lsu_wdata_i;
          end else begin
            cmd_be   = '1;
            cmd_addr = bus.if_addr_i;
          end

          if (bus.mem_gnt_i) begin
            lock_valid_next = 1'b0;
            if (sel_owner == OWNER_LSU) begin
              bus.lsu_gnt_o = 1'b1;
              state_next    = ARB_WAIT_LSU;
            end else begin
              bus.if_gnt_o = 1'b1;
              state_next   = ARB_WAIT_IF;
            end
          end else begin
            lock_valid_next = 1'b1;
            lock_owner_next = sel_owner;
          end
        end
      end

      ARB_WAIT_IF: begin
        if (bus.mem_rvalid_i) begin
          bus.if_rvalid_o = 1'b1;
          state_next      = ARB_IDLE;
        end
      end

      ARB_WAIT_LSU: begin
        if (bus.mem_rvalid_i) begin
          bus.lsu_rvalid_o = 1'b1;
          state_next       = ARB_IDLE;
        end
      end

      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  assign bus.mem_we_o    = cmd_we;
  assign bus.mem_be_o    = cmd_be;
  assign bus.mem_addr_o  = cmd_addr;
  assign bus.mem_wdata_o = cmd_wdata;

  assign bus.if_rdata_o  = bus.mem_rdata_i;
  assign bus.lsu_rdata_o = bus.mem_rdata_i;
  assign bus.busy_o      = (state != ARB_IDLE);

endmodule

`default_nettype wire
